// File: rtl/mem_arb_if.sv
// Signal bundle between the two requesters, the arbiter and the memory bus.
// All handshake outputs are driven by the arbiter; requesters and the bus model sit on the master side.
interface mem_arb_if;
    logic       req0;
    logic       req1;
    logic       rw0;
    logic       rw1;
    logic [6:0] addr0;
    logic [6:0] addr1;
    logic [7:0] wdata0;
    logic [7:0] wdata1;
    logic       ack0;
    logic       ack1;
    logic [7:0] rdata;
    logic       busy;
    logic [6:0] mem_addr;
    logic [7:0] mem_dout;
    logic [7:0] mem_din;
    logic       mem_oe;
    logic       mem_read_n;
    logic       mem_write_n;
    logic [1:0] dbg_state;

    // Handshake: a requester raises reqN with rwN/addrN/wdataN stable and keeps them
    // stable until ackN; ackN is a single-cycle pulse in HOLD, and dropping reqN before
    // it is granted withdraws the request without any ack.
    modport slave (
        input  req0, req1, rw0, rw1, addr0, addr1, wdata0, wdata1, mem_din,
        output ack0, ack1, rdata, busy, mem_addr, mem_dout, mem_oe,
        output mem_read_n, mem_write_n, dbg_state
    );

    modport master (
        output req0, req1, rw0, rw1, addr0, addr1, wdata0, wdata1, mem_din,
        input  ack0, ack1, rdata, busy, mem_addr, mem_dout, mem_oe,
        input  mem_read_n, mem_write_n, dbg_state
    );
endinterface

// File: rtl/mem_arb.sv
// Two-requester round-robin arbiter driving an asynchronous SRAM-style bus
// with a SETUP / STROBE (WAIT cycles) / HOLD access sequence.
module mem_arb #(
    parameter int unsigned WAIT = 2
) (
    input  logic     clk,
    input  logic     reset_n,
    mem_arb_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_cnt;
    logic       r_last;
    logic       r_gnt;
    logic       r_rw;
    logic [6:0] r_addr;
    logic [7:0] r_wdata;
    logic [7:0] r_rdata;
    logic       w_gnt;
    logic       w_start;
    logic       w_last_strobe;

    // r_last names the requester granted most recently; requester 0 wins unless
    // only requester 1 is asking or both ask and 0 was the last one served.
    assign w_gnt         = ~(bus.req0 & (~bus.req1 | r_last));
    assign w_start       = bus.req0 | bus.req1;
    assign w_last_strobe = (r_cnt == 4'd1);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start) w_next = SETUP;
            SETUP:   w_next = STROBE;
            STROBE:  if (w_last_strobe) w_next = HOLD;
            HOLD:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_last  <= 1'b1;
            r_gnt   <= 1'b0;
            r_rw    <= 1'b0;
            r_addr  <= 7'h00;
            r_wdata <= 8'h00;
            r_rdata <= 8'h00;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_gnt   <= w_gnt;
                        r_last  <= w_gnt;
                        r_rw    <= w_gnt ? bus.rw1    : bus.rw0;
                        r_addr  <= w_gnt ? bus.addr1  : bus.addr0;
                        r_wdata <= w_gnt ? bus.wdata1 : bus.wdata0;
                    end
                end
                SETUP: r_cnt <= WAIT_CNT;
                STROBE: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (w_last_strobe && r_rw) r_rdata <= bus.mem_din;
                end
                default: ;
            endcase
        end
    end

    // Bus controls are decoded from state so a reset leaves them inactive on the very next cycle.
    assign bus.busy        = (r_state != IDLE);
    assign bus.mem_oe      = (r_state != IDLE) && !r_rw;
    assign bus.mem_read_n  = !((r_state == STROBE) && r_rw);
    assign bus.mem_write_n = !((r_state == STROBE) && !r_rw);
    assign bus.ack0        = (r_state == HOLD) && !r_gnt;
    assign bus.ack1        = (r_state == HOLD) && r_gnt;
    assign bus.mem_addr    = r_addr;
    assign bus.mem_dout    = r_wdata;
    assign bus.rdata       = r_rdata;
    assign bus.dbg_state   = r_state;

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: WAIT=2 main instance plus WAIT=1 and WAIT=15 instances for the latency sweep.
// Inputs change and outputs are sampled on the falling edge; cycle i is the i-th falling edge after a req is driven.
module tb_mem_arb;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_pass;

    mem_arb_if bus();
    mem_arb_if bus1();
    mem_arb_if bus15();

    mem_arb #(.WAIT(2))  dut   (.clk(clk), .reset_n(reset_n), .bus(bus));
    mem_arb #(.WAIT(1))  dut1  (.clk(clk), .reset_n(reset_n), .bus(bus1));
    mem_arb #(.WAIT(15)) dut15 (.clk(clk), .reset_n(reset_n), .bus(bus15));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.req0 = 0; bus.req1 = 0; bus.rw0 = 0; bus.rw1 = 0;
        bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0; bus.mem_din = '0;
        bus1.req0 = 0; bus1.req1 = 0; bus1.rw0 = 0; bus1.rw1 = 0;
        bus1.addr0 = '0; bus1.addr1 = '0; bus1.wdata0 = '0; bus1.wdata1 = '0; bus1.mem_din = '0;
        bus15.req0 = 0; bus15.req1 = 0; bus15.rw0 = 0; bus15.rw1 = 0;
        bus15.addr0 = '0; bus15.addr1 = '0; bus15.wdata0 = '0; bus15.wdata1 = '0; bus15.mem_din = '0;
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else n_pass++;
        n_checks++; if (bus.mem_read_n !== 1'b1) $display("FAIL reset_read_n: got %b want 1", bus.mem_read_n); else n_pass++;
        n_checks++; if (bus.mem_write_n !== 1'b1) $display("FAIL reset_write_n: got %b want 1", bus.mem_write_n); else n_pass++;
        n_checks++; if (bus.mem_oe !== 1'b0) $display("FAIL reset_oe: got %b want 0", bus.mem_oe); else n_pass++;
        n_checks++; if ({bus.ack0, bus.ack1} !== 2'b00) $display("FAIL reset_ack: got %b want 00", {bus.ack0, bus.ack1}); else n_pass++;
        n_checks++; if (bus.rdata !== 8'h00) $display("FAIL reset_rdata: got %h want 00", bus.rdata); else n_pass++;
        n_checks++; if (bus.mem_addr !== 7'h00) $display("FAIL reset_addr: got %h want 00", bus.mem_addr); else n_pass++;
        n_checks++; if (bus.mem_dout !== 8'h00) $display("FAIL reset_dout: got %h want 00", bus.mem_dout); else n_pass++;
        n_checks++; if (bus.dbg_state !== 2'd0) $display("FAIL reset_state: got %0d want 0", bus.dbg_state); else n_pass++;
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_read();
        int rd_low = 0;
        int ack_cyc = -1;
        bit oe_seen = 0;
        bus.req0 = 1; bus.rw0 = 1; bus.addr0 = 7'h55; bus.mem_din = 8'hAA;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (!bus.mem_read_n) rd_low++;
            if (bus.mem_oe) oe_seen = 1;
            if (bus.ack0 && ack_cyc < 0) ack_cyc = i;
            if (i == 3) begin
                n_checks++; if (bus.mem_addr !== 7'h55) $display("FAIL rd_addr: got %h want 55", bus.mem_addr); else n_pass++;
            end
            if (i == 4) begin
                n_checks++; if (bus.rdata !== 8'hAA) $display("FAIL rd_rdata: got %h want aa", bus.rdata); else n_pass++;
                bus.req0 = 0; bus.mem_din = 8'h11;
            end
        end
        n_checks++; if (rd_low !== 2) $display("FAIL rd_strobe_width: got %0d want 2", rd_low); else n_pass++;
        n_checks++; if (ack_cyc !== 4) $display("FAIL rd_ack_latency: got %0d want 4", ack_cyc); else n_pass++;
        n_checks++; if (oe_seen !== 1'b0) $display("FAIL rd_oe: got %b want 0", oe_seen); else n_pass++;
        n_checks++; if (bus.rdata !== 8'hAA) $display("FAIL rd_rdata_hold: got %h want aa", bus.rdata); else n_pass++;
    endtask

    task automatic test_single_write();
        int wr_low = 0;
        int ack_cnt = 0;
        int oe_bad = 0;
        bus.req1 = 1; bus.rw1 = 0; bus.addr1 = 7'h12; bus.wdata1 = 8'h3C;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (!bus.mem_write_n) wr_low++;
            if (bus.ack1) ack_cnt++;
            if (bus.ack0) ack_cnt += 10;
            if ((i <= 4) && (!bus.mem_oe || bus.mem_dout !== 8'h3C)) oe_bad++;
            if ((i > 4) && bus.mem_oe) oe_bad++;
            if (i == 4) bus.req1 = 0;
        end
        n_checks++; if (wr_low !== 2) $display("FAIL wr_strobe_width: got %0d want 2", wr_low); else n_pass++;
        n_checks++; if (ack_cnt !== 1) $display("FAIL wr_ack_count: got %0d want 1", ack_cnt); else n_pass++;
        n_checks++; if (oe_bad !== 0) $display("FAIL wr_oe_dout: got %0d bad cycles want 0", oe_bad); else n_pass++;
        n_checks++; if (bus.rdata !== 8'hAA) $display("FAIL wr_rdata_kept: got %h want aa", bus.rdata); else n_pass++;
    endtask

    task automatic test_tie();
        int n_acks = 0;
        int order[8];
        int exp_order[4];
        int bad = 0;
        bit prev_ack = 0;
        exp_order = '{0, 1, 0, 1};
        pulse_reset();
        bus.req0 = 1; bus.rw0 = 1; bus.addr0 = 7'h01;
        bus.req1 = 1; bus.rw1 = 1; bus.addr1 = 7'h02; bus.mem_din = 8'h44;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (!bus.mem_read_n && !bus.mem_write_n) bad++;
            if (bus.ack0 && bus.ack1) bad++;
            if ((bus.ack0 || bus.ack1) && prev_ack) bad++;
            prev_ack = bus.ack0 || bus.ack1;
            if ((bus.ack0 || bus.ack1) && n_acks < 8) begin
                order[n_acks] = bus.ack1 ? 1 : 0;
                n_acks++;
            end
            if ((i == 5 || i == 10 || i == 15) && bus.busy) bad++;
            if (i == 19) begin bus.req0 = 0; bus.req1 = 0; end
        end
        n_checks++; if (n_acks !== 4) $display("FAIL tie_ack_count: got %0d want 4", n_acks); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (k >= n_acks || order[k] !== exp_order[k])
                $display("FAIL tie_order[%0d]: got %0d want %0d", k, (k < n_acks) ? order[k] : -1, exp_order[k]);
            else n_pass++;
        end
        n_checks++; if (bad !== 0) $display("FAIL tie_protocol: got %0d violations want 0", bad); else n_pass++;
    endtask

    task automatic test_reset_mid_strobe();
        int ack0_first = -1;
        int ack0_cnt = 0;
        int ack1_cnt = 0;
        bus.req0 = 1; bus.rw0 = 0; bus.addr0 = 7'h33; bus.wdata0 = 8'h5A; bus.req1 = 0;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            if (bus.ack0) begin ack0_cnt++; if (ack0_first < 0) ack0_first = i; end
            if (bus.ack1) ack1_cnt++;
            if (i == 2) begin
                n_checks++; if (bus.mem_write_n !== 1'b0) $display("FAIL rst_pre_strobe: got %b want 0", bus.mem_write_n); else n_pass++;
                reset_n = 1'b0;
            end
            if (i == 3) begin
                n_checks++; if (bus.mem_write_n !== 1'b1) $display("FAIL rst_write_n: got %b want 1", bus.mem_write_n); else n_pass++;
                n_checks++; if (bus.mem_oe !== 1'b0) $display("FAIL rst_oe: got %b want 0", bus.mem_oe); else n_pass++;
                n_checks++; if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus.busy); else n_pass++;
                n_checks++; if (bus.rdata !== 8'h00) $display("FAIL rst_rdata: got %h want 00", bus.rdata); else n_pass++;
                reset_n = 1'b1;
                bus.req1 = 1; bus.rw1 = 1; bus.addr1 = 7'h44;
            end
            if (i == 5) begin
                n_checks++; if (bus.mem_addr !== 7'h33) $display("FAIL rst_regrant_addr: got %h want 33", bus.mem_addr); else n_pass++;
            end
            if (i == 7) begin bus.req0 = 0; bus.req1 = 0; end
        end
        n_checks++; if (ack0_first !== 7) $display("FAIL rst_ack0_cycle: got %0d want 7", ack0_first); else n_pass++;
        n_checks++; if ({ack0_cnt, ack1_cnt} !== {32'd1, 32'd0}) $display("FAIL rst_ack_counts: got %0d/%0d want 1/0", ack0_cnt, ack1_cnt); else n_pass++;
    endtask

    task automatic test_stability();
        bus.req0 = 1; bus.rw0 = 1; bus.addr0 = 7'h21; bus.mem_din = 8'h96;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 2) begin bus.addr0 = 7'h7F; bus.rw0 = 0; bus.wdata0 = 8'hFF; end
            if (i == 3) begin
                n_checks++; if (bus.mem_addr !== 7'h21) $display("FAIL stab_addr: got %h want 21", bus.mem_addr); else n_pass++;
                n_checks++; if ({bus.mem_read_n, bus.mem_oe} !== 2'b00) $display("FAIL stab_op: got %b want 00", {bus.mem_read_n, bus.mem_oe}); else n_pass++;
            end
            if (i == 4) begin
                n_checks++; if ({bus.ack0, bus.rdata} !== {1'b1, 8'h96}) $display("FAIL stab_ack_rdata: got %b/%h want 1/96", bus.ack0, bus.rdata); else n_pass++;
                bus.req0 = 0;
            end
        end
    endtask

    task automatic test_dropped_request();
        int ack0_cnt = 0;
        int ack1_cnt = 0;
        bus.req0 = 1; bus.rw0 = 0; bus.addr0 = 7'h66; bus.wdata0 = 8'h81;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (bus.ack0) ack0_cnt++;
            if (bus.ack1) ack1_cnt++;
            if (i == 1) begin bus.req1 = 1; bus.rw1 = 1; bus.addr1 = 7'h0F; end
            if (i == 2) bus.req1 = 0;
            if (i == 4) bus.req0 = 0;
        end
        n_checks++; if (ack1_cnt !== 0) $display("FAIL drop_ack1: got %0d want 0", ack1_cnt); else n_pass++;
        n_checks++; if (ack0_cnt !== 1) $display("FAIL drop_ack0: got %0d want 1", ack0_cnt); else n_pass++;
        n_checks++; if (bus.rdata !== 8'h96) $display("FAIL drop_rdata_kept: got %h want 96", bus.rdata); else n_pass++;
    endtask

    task automatic test_wait_sweep();
        int low1 = 0;
        int low15 = 0;
        int ack1_cyc = -1;
        int ack15_cyc = -1;
        bus1.req0 = 1; bus1.rw0 = 1; bus1.addr0 = 7'h0A; bus1.mem_din = 8'hC3;
        bus15.req0 = 1; bus15.rw0 = 1; bus15.addr0 = 7'h0A; bus15.mem_din = 8'h3C;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (!bus1.mem_read_n) low1++;
            if (!bus15.mem_read_n) low15++;
            if (bus1.ack0 && ack1_cyc < 0) begin ack1_cyc = i; bus1.req0 = 0; end
            if (bus15.ack0 && ack15_cyc < 0) begin ack15_cyc = i; bus15.req0 = 0; end
            if (i == 5) bus15.addr0 = 7'h7F;
            if (i == 10) begin
                n_checks++; if (bus15.mem_addr !== 7'h0A) $display("FAIL w15_addr_held: got %h want 0a", bus15.mem_addr); else n_pass++;
            end
        end
        n_checks++; if (low1 !== 1) $display("FAIL w1_strobe_width: got %0d want 1", low1); else n_pass++;
        n_checks++; if (ack1_cyc !== 3) $display("FAIL w1_ack_latency: got %0d want 3", ack1_cyc); else n_pass++;
        n_checks++; if (bus1.rdata !== 8'hC3) $display("FAIL w1_rdata: got %h want c3", bus1.rdata); else n_pass++;
        n_checks++; if (low15 !== 15) $display("FAIL w15_strobe_width: got %0d want 15", low15); else n_pass++;
        n_checks++; if (ack15_cyc !== 17) $display("FAIL w15_ack_latency: got %0d want 17", ack15_cyc); else n_pass++;
        n_checks++; if (bus15.rdata !== 8'h3C) $display("FAIL w15_rdata: got %h want 3c", bus15.rdata); else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset_n  = 1'b0;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_single_read();
        test_single_write();
        test_tie();
        test_reset_mid_strobe();
        test_stability();
        test_dropped_request();
        test_wait_sweep();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
